// File: rtl/alu_issue_ctrl.sv
// Initiator side of the 8-bit ALU interface: issues 16-bit instructions to an external
// combinational ALU, holds its operands, captures the result and retires it into a register file.
module alu_issue_ctrl #(
    parameter int REG_AW      = 3,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [15:0]       inst,
    output logic [7:0]        alu_reg1,
    output logic [7:0]        alu_reg2,
    output logic [3:0]        alu_func,
    output logic [2:0]        alu_spec_fun,
    input  logic [7:0]        alu_res,
    input  logic              alu_carry,
    input  logic              alu_br,
    output logic              done,
    output logic              br_valid,
    output logic              br_taken,
    output logic              carry_flag,
    output logic              illegal,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);
    localparam int NREGS = 1 << REG_AW;
    localparam int HOLD  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

    localparam logic [3:0] F_ADD  = 4'b0000;
    localparam logic [3:0] F_SL   = 4'b0011;
    localparam logic [3:0] F_SR   = 4'b0100;
    localparam logic [3:0] F_STT  = 4'b0101;
    localparam logic [3:0] F_STF  = 4'b0110;
    localparam logic [3:0] F_SPEC = 4'b0111;
    localparam logic [3:0] F_SLW  = 4'b1010;
    localparam logic [3:0] F_SHG  = 4'b1011;
    localparam logic [3:0] F_BE   = 4'b1100;
    localparam logic [3:0] F_BLT  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  hold_cnt;
    logic [7:0]        regs [NREGS];
    logic [REG_AW-1:0] rd_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr_q;
    logic [7:0]        res_q;
    logic              carry_q;
    logic              br_q;
    logic              handshake;
    logic              spec_ok;
    logic              do_write;
    logic              do_carry;
    logic              is_branch;
    logic              is_illegal;
    logic              unused_bits;

    assign rd_addr     = REG_AW'(inst[11:9]);
    assign rs2_addr    = REG_AW'(inst[7:5]);
    assign unused_bits = inst[3];
    assign inst_ready  = (state == IDLE);
    assign handshake   = inst_valid && inst_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ISSUE)
                hold_cnt <= hold_cnt + 1'b1;
            else
                hold_cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = ISSUE;
            ISSUE:   if (hold_cnt == HOLD_LAST) state_next = CAPTURE;
            CAPTURE: state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand snapshot at the handshake keeps the ALU inputs frozen until the next instruction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_reg1     <= '0;
            alu_reg2     <= '0;
            alu_func     <= '0;
            alu_spec_fun <= '0;
            rd_addr_q    <= '0;
        end else if (handshake) begin
            alu_reg1     <= regs[rd_addr];
            alu_reg2     <= inst[8] ? {4'b0000, inst[7:4]} : regs[rs2_addr];
            alu_func     <= inst[15:12];
            alu_spec_fun <= inst[2:0];
            rd_addr_q    <= rd_addr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            br_q    <= 1'b0;
        end else if (state == CAPTURE) begin
            res_q   <= alu_res;
            carry_q <= alu_carry;
            br_q    <= alu_br;
        end
    end

    assign spec_ok = (alu_spec_fun == 3'b000) || (alu_spec_fun == 3'b001) ||
                     (alu_spec_fun == 3'b011) || (alu_spec_fun == 3'b100);

    always_comb begin
        do_write   = 1'b0;
        do_carry   = 1'b0;
        is_branch  = 1'b0;
        is_illegal = 1'b0;
        case (alu_func)
            F_ADD: begin
                do_write = 1'b1;
                do_carry = 1'b1;
            end
            F_SL, F_SR, F_STT, F_STF, F_SLW, F_SHG: do_write = 1'b1;
            F_SPEC: begin
                do_write   = spec_ok;
                is_illegal = !spec_ok;
            end
            F_BE, F_BLT: is_branch = 1'b1;
            default:     is_illegal = 1'b1;
        endcase
    end

    assign done     = (state == WRITE);
    assign br_valid = done && is_branch;
    assign br_taken = br_valid && br_q;
    assign illegal  = done && is_illegal;

    // Retirement lands on the edge leaving WRITE, so a following snapshot sees the new value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            carry_flag <= 1'b0;
        end else if (state == WRITE) begin
            if (do_write)
                regs[rd_addr_q] <= res_q;
            if (do_carry)
                carry_flag <= carry_q;
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule
